mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath (PC, instruction/data memory, RegFile, ALU, sign-extend, muxes).
- Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives every datapath select and write strobe from a Moore FSM.
- Stalls on a memory ready handshake and counts retired instructions.
- Replaces the single-cycle ControlUNIT when the shared-memory multi-cycle datapath is built.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = execute instructions; 0 = park in IDLE at the next instruction boundary
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_source  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  RegFile write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- reg_write  out  1  RegFile write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- state  out  4  current state encoding, for debug
- illegal  out  1  sticky: an unsupported opcode was decoded
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE(0), illegal = 0, instr_count = 0.
  - All control outputs 0 while in IDLE.
- Outputs are combinational from state only (Moore). mem_ready gates only state advance and the pc_write/ir_write strobes.
- IDLE(0): run = 1 -> FETCH.
- FETCH(1):
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 00, pc_source = 0.
  - ir_write = pc_write = mem_ready.
  - Stay while mem_ready = 0; else -> DECODE.
- DECODE(2): alu_src_a = 0, alu_src_b = 3, alu_op = 00. Next state by opcode:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - 001000 addi -> ADDIEX
  - any other -> TRAP
- MEMADR(3): alu_src_a = 1, alu_src_b = 2, alu_op = 00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD(4): mem_read = 1, i_or_d = 1. Stay until mem_ready, then -> MEMWB.
- MEMWB(5): reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retire.
- MEMWR(6): mem_write = 1, i_or_d = 1. Stay until mem_ready, then retire.
- EXEC(7): alu_src_a = 1, alu_src_b = 0, alu_op = 10. -> RWB.
- RWB(8): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retire.
- BRANCH(9): alu_src_a = 1, alu_src_b = 0, alu_op = 01, pc_write_cond = 1, pc_source = 1. Retire.
- JUMP(10): pc_write = 1, pc_source = 2. Retire.
- ADDIEX(11): alu_src_a = 1, alu_src_b = 2, alu_op = 00. -> ADDIWB.
- ADDIWB(12): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retire.
- TRAP(13): all outputs 0; illegal set to 1. Stay until reset.
- Retire:
  - instr_count += 1 on the clock edge leaving the retiring state; wraps modulo 2^CNT_W.
  - Next state is FETCH if run = 1, else IDLE.
- run deasserted mid-instruction: the instruction completes; run is sampled only at IDLE and at retire.
- Latency with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Each 0 on mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- mem_read/mem_write stay asserted and stable through a stall.
- Unused state codes 14–15 -> IDLE on the next clock.
- Reset mid-instruction aborts immediately. No write strobe is asserted during or after reset until a new FETCH.

Test Plan:
- Reset, run = 1, mem_ready = 1, opcode = 000000 -> states 1,2,7,8,1. reg_write = 1 only in the RWB cycle. instr_count = 1 after 4 cycles.
- lw (100011), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with mem_read = 1, i_or_d = 1. Total 7 cycles; MEMWB asserts reg_write = 1, mem_to_reg = 1.
- beq then j, mem_ready = 1 -> 3 cycles each. BRANCH shows pc_write_cond = 1, alu_op = 01; JUMP shows pc_write = 1, pc_source = 2. instr_count = 2.
- FETCH with mem_ready = 0 for 3 cycles -> ir_write = pc_write = 0 throughout. Both 1 only in the ready cycle. State stays 1 until then.
- opcode = 111111 -> DECODE -> TRAP. illegal = 1, all strobes 0, instr_count unchanged. rst_n pulse -> IDLE, illegal = 0.
- run dropped during EXEC of R-type -> RWB completes, then IDLE (state 0). run = 1 again -> FETCH next cycle. Async rst_n low mid-MEMWR -> mem_write = 0 with no clock edge.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS sequencer: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and strobe.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   illegal_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP)
                illegal_q <= 1'b1;
            if (retire)
                count_q <= count_q + CNT_W'(1);
        end
    end

    // An instruction retires on the edge that leaves its final step.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        retire  = 1'b0;
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand-written corner sequences,
// and randomized run/opcode/mem_ready traffic against a step-list reference model.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]       pc_source, alu_src_b, alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic [15:0]      ctrl;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal(illegal), .instr_count(instr_count)
    );

    assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each opcode expands into the list of steps it walks after DECODE.
    int               m_state;
    int               plan[$];
    logic             m_illegal;
    logic [CNT_W-1:0] m_count;

    task automatic load_plan(input logic [5:0] op);
        plan.delete();
        case (op)
            6'b100011: begin plan.push_back(3); plan.push_back(4); plan.push_back(5); end
            6'b101011: begin plan.push_back(3); plan.push_back(6); end
            6'b000000: begin plan.push_back(7); plan.push_back(8); end
            6'b000100: plan.push_back(9);
            6'b000010: plan.push_back(10);
            6'b001000: begin plan.push_back(11); plan.push_back(12); end
            default:   plan.push_back(13);
        endcase
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_illegal = 1'b0;
        m_count   = '0;
        plan.delete();
    endtask

    task automatic model_step(input logic r, input logic rdy, input logic [5:0] op);
        if (m_state == 0) begin
            m_state = r ? 1 : 0;
        end else if (m_state == 1) begin
            if (rdy) m_state = 2;
        end else if (m_state == 2) begin
            load_plan(op);
            m_state = plan.pop_front();
            if (m_state == 13) m_illegal = 1'b1;
        end else if (m_state == 13) begin
            m_state = 13;
        end else if ((m_state == 4 || m_state == 6) && !rdy) begin
            m_state = m_state;
        end else if (plan.size() > 0) begin
            m_state = plan.pop_front();
        end else begin
            m_count = m_count + 1'b1;
            m_state = r ? 1 : 0;
        end
    endtask

    // Expected control word per step, in the same field order as ctrl.
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] ps, asb, aop;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
        {ps, asb, aop} = '0;
        case (st)
            1:  begin mr = 1; asb = 2'd1; pw = rdy; irw = rdy; end
            2:  asb = 2'd3;
            3:  begin asa = 1; asb = 2'd2; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'd1; end
            10: begin pw = 1; ps = 2'd2; end
            11: begin asa = 1; asb = 2'd2; end
            12: rw = 1;
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop};
    endfunction

    typedef struct {
        logic             run;
        logic [5:0]       op;
        logic             rdy;
        logic [3:0]       st;
        logic             mr, mw, rw, pw, irw, iod;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                                input logic [3:0] st, input logic mr, input logic mw,
                                input logic rw, input logic pw, input logic irw,
                                input logic iod, input logic [CNT_W-1:0] cnt);
        vec_t v;
        v.run = r; v.op = op; v.rdy = rdy; v.st = st; v.mr = mr; v.mw = mw;
        v.rw = rw; v.pw = pw; v.irw = irw; v.iod = iod; v.cnt = cnt;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(1, 6'b000000, 1, 4'd1, 1, 0, 0, 1, 1, 0, 4'd0);
        vecs[1]  = mk(1, 6'b000000, 1, 4'd2, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[2]  = mk(1, 6'b000000, 1, 4'd7, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[3]  = mk(1, 6'b000000, 1, 4'd8, 0, 0, 1, 0, 0, 0, 4'd0);
        vecs[4]  = mk(1, 6'b000000, 1, 4'd1, 1, 0, 0, 1, 1, 0, 4'd1);
        vecs[5]  = mk(1, 6'b100011, 1, 4'd2, 0, 0, 0, 0, 0, 0, 4'd1);
        vecs[6]  = mk(1, 6'b100011, 1, 4'd3, 0, 0, 0, 0, 0, 0, 4'd1);
        vecs[7]  = mk(1, 6'b100011, 1, 4'd4, 1, 0, 0, 0, 0, 1, 4'd1);
        vecs[8]  = mk(1, 6'b100011, 0, 4'd4, 1, 0, 0, 0, 0, 1, 4'd1);
        vecs[9]  = mk(1, 6'b100011, 0, 4'd4, 1, 0, 0, 0, 0, 1, 4'd1);
        vecs[10] = mk(1, 6'b100011, 1, 4'd5, 0, 0, 1, 0, 0, 0, 4'd1);
        vecs[11] = mk(1, 6'b100011, 1, 4'd1, 1, 0, 0, 1, 1, 0, 4'd2);
        vecs[12] = mk(1, 6'b000000, 0, 4'd1, 1, 0, 0, 0, 0, 0, 4'd2);
        vecs[13] = mk(1, 6'b000000, 0, 4'd1, 1, 0, 0, 0, 0, 0, 4'd2);
        vecs[14] = mk(1, 6'b000000, 0, 4'd1, 1, 0, 0, 0, 0, 0, 4'd2);
        vecs[15] = mk(1, 6'b000000, 1, 4'd2, 0, 0, 0, 0, 0, 0, 4'd2);
        vecs[16] = mk(1, 6'b000000, 1, 4'd7, 0, 0, 0, 0, 0, 0, 4'd2);
        vecs[17] = mk(1, 6'b000000, 1, 4'd8, 0, 0, 1, 0, 0, 0, 4'd2);
        vecs[18] = mk(1, 6'b000000, 1, 4'd1, 1, 0, 0, 1, 1, 0, 4'd3);

        // Reset state.
        reset_dut();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);

        // R-type, lw with MEMRD stall, FETCH stall, R-type.
        for (int i = 0; i < 19; i++) begin
            run = vecs[i].run; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
            step();
            check($sformatf("tv%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("tv%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].mr));
            check($sformatf("tv%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
            check($sformatf("tv%0d_reg_write", i), 32'(reg_write), 32'(vecs[i].rw));
            check($sformatf("tv%0d_pc_write", i), 32'(pc_write), 32'(vecs[i].pw));
            check($sformatf("tv%0d_ir_write", i), 32'(ir_write), 32'(vecs[i].irw));
            check($sformatf("tv%0d_i_or_d", i), 32'(i_or_d), 32'(vecs[i].iod));
            check($sformatf("tv%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
        end

        // beq then j.
        reset_dut();
        run = 1; mem_ready = 1; opcode = 6'b000100;
        step(); step(); step();
        check("beq_state", 32'(state), 32'd9);
        check("beq_pwc", 32'(pc_write_cond), 32'd1);
        check("beq_alu_op", 32'(alu_op), 32'd1);
        check("beq_pc_source", 32'(pc_source), 32'd1);
        opcode = 6'b000010;
        step(); step(); step();
        check("j_state", 32'(state), 32'd10);
        check("j_pc_write", 32'(pc_write), 32'd1);
        check("j_pc_source", 32'(pc_source), 32'd2);
        step();
        check("bj_count", 32'(instr_count), 32'd2);

        // Illegal opcode traps until reset.
        reset_dut();
        run = 1; mem_ready = 1; opcode = 6'b111111;
        step(); step(); step();
        check("trap_state", 32'(state), 32'd13);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_ctrl", 32'(ctrl), 32'd0);
        step();
        check("trap_hold", 32'(state), 32'd13);
        check("trap_count", 32'(instr_count), 32'd0);
        rst_n = 0;
        #1;
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1;

        // run dropped during EXEC: finish, park in IDLE, restart.
        reset_dut();
        run = 1; mem_ready = 1; opcode = 6'b000000;
        step(); step(); step();
        check("drop_exec", 32'(state), 32'd7);
        run = 0;
        step();
        check("drop_rwb", 32'(state), 32'd8);
        step();
        check("drop_idle", 32'(state), 32'd0);
        check("drop_count", 32'(instr_count), 32'd1);
        step();
        check("drop_stay_idle", 32'(state), 32'd0);
        run = 1;
        step();
        check("drop_refetch", 32'(state), 32'd1);

        // Async reset mid-MEMWR drops mem_write without a clock edge.
        reset_dut();
        run = 1; mem_ready = 1; opcode = 6'b101011;
        step(); step();
        mem_ready = 0;
        step(); step();
        check("sw_state", 32'(state), 32'd6);
        check("sw_mem_write", 32'(mem_write), 32'd1);
        step();
        check("sw_stall_hold", 32'(mem_write), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("sw_rst_mem_write", 32'(mem_write), 32'd0);
        check("sw_rst_state", 32'(state), 32'd0);
        #1;
        rst_n = 1;

        // Random traffic against the model; small CNT_W exercises counter wrap.
        reset_dut();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       r, rdy;
            logic [5:0] op;
            int         pick;
            if (($urandom % 200 == 0) || (m_state == 13 && $urandom % 3 == 0)) begin
                rst_n = 0;
                #1;
                check("rnd_rst_ctrl", 32'(ctrl), 32'd0);
                rst_n = 1;
                model_reset();
            end
            r   = ($urandom % 10) != 0;
            rdy = ($urandom % 4) != 0;
            op  = opcode;
            if (m_state == 0 || m_state == 1) begin
                pick = int'($urandom % 16);
                case (pick % 6)
                    0: op = 6'b100011;
                    1: op = 6'b101011;
                    2: op = 6'b000000;
                    3: op = 6'b000100;
                    4: op = 6'b000010;
                    default: op = 6'b001000;
                endcase
                if (pick == 15) op = 6'($urandom);
            end
            run = r; mem_ready = rdy; opcode = op;
            #1;
            check("rnd_state", 32'(state), 32'(m_state));
            check("rnd_ctrl", 32'(ctrl), 32'(exp_ctrl(m_state, rdy)));
            check("rnd_illegal", 32'(illegal), 32'(m_illegal));
            check("rnd_count", 32'(instr_count), 32'(m_count));
            @(posedge clk);
            model_step(r, rdy, op);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
